// File: rtl/vector_fifo_stream.sv
// Streaming element-wise vector adder: two show-ahead operand FIFOs feed an adder
// whose sums are buffered in an output FIFO, sequenced by an IDLE/COMPUTE/DONE FSM.

module StreamFifo #(
    parameter int WIDTH     = 16,
    parameter int ADDR_BITS = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wrEn_i,
    input  logic [WIDTH-1:0] wrData_i,
    input  logic             rdEn_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int DEPTH = 1 << ADDR_BITS;
    localparam int CW    = ADDR_BITS + 1;

    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic [ADDR_BITS-1:0] wrPtr_q, rdPtr_q;
    logic [CW-1:0]        count_q;
    logic                 doWrite, doRead;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rdPtr_q];
    assign doRead  = rdEn_i && !empty_o;
    // A write into a full FIFO still lands when the head is popped in the same cycle.
    assign doWrite = wrEn_i && (!full_o || doRead);

    always_ff @(posedge clk) begin
        if (doWrite) begin
            mem_q[wrPtr_q] <= wrData_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doWrite) begin
                wrPtr_q <= wrPtr_q + ADDR_BITS'(1);
            end
            if (doRead) begin
                rdPtr_q <= rdPtr_q + ADDR_BITS'(1);
            end
            if (doWrite && !doRead) begin
                count_q <= count_q + CW'(1);
            end else if (doRead && !doWrite) begin
                count_q <= count_q - CW'(1);
            end
        end
    end
endmodule

module vector_fifo_stream #(
    parameter int DATA_WIDTH    = 16,
    parameter int LENGTH_BITS   = 8,
    parameter int BUFFER_LENGTH = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   data_in_v1_en,
    input  logic [DATA_WIDTH-1:0]  data_in_v1,
    output logic                   data_in_v1_full,
    input  logic                   data_in_v2_en,
    input  logic [DATA_WIDTH-1:0]  data_in_v2,
    output logic                   data_in_v2_full,
    input  logic                   data_out_en,
    output logic [DATA_WIDTH-1:0]  data_out,
    output logic                   data_out_empty,
    input  logic [LENGTH_BITS-1:0] vector_length,
    input  logic                   start,
    output logic                   done,
    output logic                   idle,
    output logic                   ready
);
    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

    state_t                 state_q, state_d;
    logic [LENGTH_BITS-1:0] len_q, len_d, cnt_q, cnt_d, cntInc;
    logic [DATA_WIDTH-1:0]  dataOut_q;
    logic [DATA_WIDTH-1:0]  v1Head, v2Head, outHead, sum;
    logic                   v1Empty, v2Empty, outFull, outEmpty;
    logic                   pushSum, outRead, inWrite1, inWrite2;

    assign inWrite1 = data_in_v1_en && (state_q == COMPUTE);
    assign inWrite2 = data_in_v2_en && (state_q == COMPUTE);
    // The counter check stops consumption once the requested length is reached,
    // leaving surplus operands queued for the next operation.
    assign pushSum  = (state_q == COMPUTE) && (cnt_q != len_q) &&
                      !v1Empty && !v2Empty && !outFull;
    assign sum      = v1Head + v2Head;
    assign outRead  = data_out_en && !outEmpty;
    assign cntInc   = cnt_q + LENGTH_BITS'(1);

    StreamFifo #(.WIDTH(DATA_WIDTH), .ADDR_BITS(BUFFER_LENGTH)) v1Fifo (
        .clk(clk), .rst(rst), .wrEn_i(inWrite1), .wrData_i(data_in_v1),
        .rdEn_i(pushSum), .head_o(v1Head), .full_o(data_in_v1_full), .empty_o(v1Empty)
    );

    StreamFifo #(.WIDTH(DATA_WIDTH), .ADDR_BITS(BUFFER_LENGTH)) v2Fifo (
        .clk(clk), .rst(rst), .wrEn_i(inWrite2), .wrData_i(data_in_v2),
        .rdEn_i(pushSum), .head_o(v2Head), .full_o(data_in_v2_full), .empty_o(v2Empty)
    );

    StreamFifo #(.WIDTH(DATA_WIDTH), .ADDR_BITS(BUFFER_LENGTH)) outFifo (
        .clk(clk), .rst(rst), .wrEn_i(pushSum), .wrData_i(sum),
        .rdEn_i(outRead), .head_o(outHead), .full_o(outFull), .empty_o(outEmpty)
    );

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = COMPUTE;
                    len_d   = vector_length;
                    cnt_d   = '0;
                end
            end
            COMPUTE: begin
                if (pushSum) begin
                    cnt_d = cntInc;
                end
                if ((len_q == '0) || (pushSum && (cntInc == len_q))) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (outEmpty) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            len_q     <= '0;
            cnt_q     <= '0;
            dataOut_q <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            if (outRead) begin
                dataOut_q <= outHead;
            end
        end
    end

    assign data_out       = dataOut_q;
    assign data_out_empty = outEmpty;
    assign idle           = (state_q == IDLE);
    assign ready          = (state_q == COMPUTE);
    assign done           = (state_q == DONE);
endmodule

// File: tb/tb_vector_fifo_stream.sv
// Self-checking bench for vector_fifo_stream: queue-based reference model compared
// every cycle, directed scenarios pinned with literal values, then randomized traffic.

module tb_vector_fifo_stream;
    localparam int DW    = 16;
    localparam int LB    = 8;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          data_in_v1_en, data_in_v2_en, data_out_en, start;
    logic [DW-1:0] data_in_v1, data_in_v2, data_out;
    logic          data_in_v1_full, data_in_v2_full, data_out_empty;
    logic [LB-1:0] vector_length;
    logic          done, idle, ready;

    always #5 clk = ~clk;

    vector_fifo_stream #(.DATA_WIDTH(DW), .LENGTH_BITS(LB), .BUFFER_LENGTH(3)) dut (
        .clk(clk), .rst(rst),
        .data_in_v1_en(data_in_v1_en), .data_in_v1(data_in_v1), .data_in_v1_full(data_in_v1_full),
        .data_in_v2_en(data_in_v2_en), .data_in_v2(data_in_v2), .data_in_v2_full(data_in_v2_full),
        .data_out_en(data_out_en), .data_out(data_out), .data_out_empty(data_out_empty),
        .vector_length(vector_length), .start(start),
        .done(done), .idle(idle), .ready(ready)
    );

    int testsRun    = 0;
    int testsFailed = 0;
    bit checkEn     = 0;
    bit sawDone     = 0;
    bit autoRead    = 0;

    logic [DW-1:0] mQ1[$], mQ2[$], mQo[$], readLog[$];
    int            mMode = 0;
    int            mLen  = 0;
    int            mCnt  = 0;
    logic [DW-1:0] mDout = '0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: mode 0 = idle, 1 = computing, 2 = done; decisions use pre-edge occupancy.
    always @(posedge clk) begin : refModel
        bit            doPush, doRead, doW1, doW2, outWasEmpty;
        logic [DW-1:0] a, b, s;
        if (rst) begin
            mQ1.delete(); mQ2.delete(); mQo.delete();
            mMode = 0; mLen = 0; mCnt = 0; mDout = '0;
        end else begin
            doPush = (mMode == 1) && (mCnt != mLen) && (mQ1.size() > 0) &&
                     (mQ2.size() > 0) && (mQo.size() < DEPTH);
            doRead = data_out_en && (mQo.size() > 0);
            doW1   = (mMode == 1) && data_in_v1_en && ((mQ1.size() < DEPTH) || doPush);
            doW2   = (mMode == 1) && data_in_v2_en && ((mQ2.size() < DEPTH) || doPush);
            outWasEmpty = (mQo.size() == 0);
            if (doRead) begin
                mDout = mQo.pop_front();
                readLog.push_back(mDout);
            end
            if (doPush) begin
                a = mQ1.pop_front();
                b = mQ2.pop_front();
                s = a + b;
                mQo.push_back(s);
                mCnt++;
            end
            if (doW1) mQ1.push_back(data_in_v1);
            if (doW2) mQ2.push_back(data_in_v2);
            case (mMode)
                0: if (start) begin mMode = 1; mLen = int'(vector_length); mCnt = 0; end
                1: if ((mLen == 0) || (doPush && (mCnt == mLen))) mMode = 2;
                default: if (outWasEmpty) mMode = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("idle", {31'd0, idle}, {31'd0, mMode == 0});
            checkOutput("ready", {31'd0, ready}, {31'd0, mMode == 1});
            checkOutput("done", {31'd0, done}, {31'd0, mMode == 2});
            checkOutput("data_out", {16'd0, data_out}, {16'd0, mDout});
            checkOutput("data_out_empty", {31'd0, data_out_empty}, {31'd0, mQo.size() == 0});
            checkOutput("v1_full", {31'd0, data_in_v1_full}, {31'd0, mQ1.size() == DEPTH});
            checkOutput("v2_full", {31'd0, data_in_v2_full}, {31'd0, mQ2.size() == DEPTH});
            if (done === 1'b1) sawDone = 1;
        end
    end

    task automatic applyStimulus(input bit e1, input logic [DW-1:0] d1, input bit e2,
                                 input logic [DW-1:0] d2, input bit rd, input bit st,
                                 input logic [LB-1:0] len);
        @(negedge clk);
        data_in_v1_en = e1;
        data_in_v1    = d1;
        data_in_v2_en = e2;
        data_in_v2    = d2;
        data_out_en   = rd | (autoRead & ~data_out_empty);
        start         = st;
        vector_length = len;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, '0, 0, '0, 0, 0, '0);
    endtask

    task automatic waitIdle(input int budget, input string tag);
        int n = 0;
        autoRead = 1;
        while (idle !== 1'b1 && n < budget) begin
            applyStimulus(0, '0, 0, '0, 0, 0, '0);
            n++;
        end
        autoRead = 0;
        checkOutput({tag, "_idleReached"}, {31'd0, idle}, 32'd1);
    endtask

    initial begin : stimulus
        logic [DW-1:0] expA [8];
        expA = '{16'h000A, 16'h000C, 16'h000E, 16'h0010, 16'h0012, 16'h0014, 16'h0016, 16'h0018};

        rst = 1'b1;
        data_in_v1_en = 0; data_in_v2_en = 0; data_out_en = 0; start = 0;
        data_in_v1 = '0; data_in_v2 = '0; vector_length = '0;
        @(posedge clk);
        @(negedge clk);
        checkEn = 1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("reset_idle", {31'd0, idle}, 32'd1);
        checkOutput("reset_ready", {31'd0, ready}, 32'd0);
        checkOutput("reset_done", {31'd0, done}, 32'd0);
        checkOutput("reset_data_out", {16'd0, data_out}, 32'd0);
        checkOutput("reset_empty", {31'd0, data_out_empty}, 32'd1);
        checkOutput("reset_v1_full", {31'd0, data_in_v1_full}, 32'd0);
        checkOutput("reset_v2_full", {31'd0, data_in_v2_full}, 32'd0);

        // Streaming with reads whenever data is available.
        readLog.delete(); sawDone = 0;
        applyStimulus(0, '0, 0, '0, 0, 1, 8'd8);
        applyStimulus(0, '0, 0, '0, 0, 0, '0);
        checkOutput("A_ready_after_start", {31'd0, ready}, 32'd1);
        checkOutput("A_idle_after_start", {31'd0, idle}, 32'd0);
        autoRead = 1;
        for (int i = 1; i <= 8; i++) applyStimulus(1, DW'(i), 1, DW'(8 + i), 0, 0, '0);
        waitIdle(40, "A");
        checkOutput("A_sawDone", {31'd0, sawDone}, 32'd1);
        checkOutput("A_count", readLog.size(), 32'd8);
        for (int i = 0; i < 8 && i < readLog.size(); i++)
            checkOutput("A_sum", {16'd0, readLog[i]}, {16'd0, expA[i]});

        // Same vectors, no reads until done.
        readLog.delete();
        applyStimulus(0, '0, 0, '0, 0, 1, 8'd8);
        for (int i = 1; i <= 8; i++) applyStimulus(1, DW'(i), 1, DW'(8 + i), 0, 0, '0);
        idleCycles(3);
        checkOutput("B_done", {31'd0, done}, 32'd1);
        checkOutput("B_not_empty", {31'd0, data_out_empty}, 32'd0);
        checkOutput("B_model_occupancy", mQo.size(), 32'd8);
        waitIdle(40, "B");
        checkOutput("B_count", readLog.size(), 32'd8);
        for (int i = 0; i < 8 && i < readLog.size(); i++)
            checkOutput("B_sum", {16'd0, readLog[i]}, {16'd0, expA[i]});

        // Output FIFO fills and stalls compute with operands still queued.
        readLog.delete();
        applyStimulus(0, '0, 0, '0, 0, 1, 8'd10);
        for (int i = 1; i <= 10; i++) applyStimulus(1, DW'(i), 1, DW'(100 + i), 0, 0, '0);
        idleCycles(5);
        checkOutput("C_stalled_ready", {31'd0, ready}, 32'd1);
        checkOutput("C_stalled_done", {31'd0, done}, 32'd0);
        waitIdle(60, "C");
        checkOutput("C_count", readLog.size(), 32'd10);
        for (int i = 0; i < 10 && i < readLog.size(); i++)
            checkOutput("C_sum", {16'd0, readLog[i]}, 32'(100 + 2 * (i + 1)));

        // Carry out of the element width is discarded.
        readLog.delete();
        applyStimulus(0, '0, 0, '0, 0, 1, 8'd1);
        applyStimulus(1, 16'hFFFF, 1, 16'h0002, 0, 0, '0);
        waitIdle(20, "OVF");
        checkOutput("OVF_count", readLog.size(), 32'd1);
        if (readLog.size() > 0) checkOutput("OVF_sum", {16'd0, readLog[0]}, 32'h0001);

        // Zero-length operation passes through DONE for exactly one cycle.
        readLog.delete();
        applyStimulus(0, '0, 0, '0, 0, 1, 8'd0);
        applyStimulus(0, '0, 0, '0, 0, 0, '0);
        checkOutput("Z_ready", {31'd0, ready}, 32'd1);
        applyStimulus(0, '0, 0, '0, 0, 0, '0);
        checkOutput("Z_done", {31'd0, done}, 32'd1);
        applyStimulus(0, '0, 0, '0, 0, 0, '0);
        checkOutput("Z_idle", {31'd0, idle}, 32'd1);
        checkOutput("Z_no_output", readLog.size(), 32'd0);

        // Reset in the middle of an operation flushes everything.
        readLog.delete();
        applyStimulus(0, '0, 0, '0, 0, 1, 8'd5);
        for (int i = 1; i <= 3; i++) applyStimulus(1, DW'(i), 1, DW'(i), 0, 0, '0);
        @(negedge clk); rst = 1'b1;
        data_in_v1_en = 0; data_in_v2_en = 0;
        @(negedge clk); rst = 1'b0;
        checkOutput("R_idle", {31'd0, idle}, 32'd1);
        checkOutput("R_empty", {31'd0, data_out_empty}, 32'd1);
        checkOutput("R_data_out", {16'd0, data_out}, 32'd0);
        applyStimulus(1, 16'h0055, 1, 16'h0066, 0, 0, '0);
        applyStimulus(1, 16'h0077, 1, 16'h0088, 0, 0, '0);
        applyStimulus(0, '0, 0, '0, 0, 1, 8'd1);
        idleCycles(4);
        checkOutput("R_idle_writes_ignored", {31'd0, ready}, 32'd1);
        checkOutput("R_still_empty", {31'd0, data_out_empty}, 32'd1);
        applyStimulus(1, 16'h0007, 1, 16'h0008, 0, 0, '0);
        waitIdle(20, "R");
        checkOutput("R_count", readLog.size(), 32'd1);
        if (readLog.size() > 0) checkOutput("R_sum", {16'd0, readLog[0]}, 32'h000F);

        // Randomized traffic, including writes into full FIFOs and spurious starts.
        for (int op = 0; op < 8; op++) begin
            int rdPct, n;
            rdPct = int'($urandom_range(20, 90));
            applyStimulus(0, '0, 0, '0, 0, 1, LB'($urandom_range(0, 20)));
            n = 0;
            while (n < 2 || (idle !== 1'b1 && n < 400)) begin
                applyStimulus($urandom_range(0, 99) < 70, DW'($urandom),
                              $urandom_range(0, 99) < 70, DW'($urandom),
                              int'($urandom_range(0, 99)) < rdPct,
                              (idle !== 1'b1) && ($urandom_range(0, 99) < 10),
                              LB'($urandom));
                n++;
            end
            checkOutput("RND_idleReached", {31'd0, idle}, 32'd1);
        end
        waitIdle(20, "END");

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule

// File: doc/vector_fifo_stream.md
# vector_fifo_stream

Streaming element-wise vector adder with FIFO buffering on both operand inputs and on the result output. Two operand streams (v1, v2) are written into independent input FIFOs. A small control FSM pops one element from each, adds them and pushes the sum into an output FIFO until `vector_length` results have been produced. It sits between an operand producer and a result consumer in the HSI-MSE datapath, decoupling both sides with flow-control flags.

## Interface
Parameters:
- DATA_WIDTH, 16: element width in bits (operands and sums).
- LENGTH_BITS, 8: width of `vector_length` and of the internal element counter.
- BUFFER_LENGTH, 3: log2 of each FIFO depth (default depth 8, all three FIFOs).

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- data_in_v1_en  in  1  write strobe for the v1 FIFO.
- data_in_v1  in  DATA_WIDTH  v1 element.
- data_in_v1_full  out  1  v1 FIFO full (combinational from occupancy).
- data_in_v2_en  in  1  write strobe for the v2 FIFO.
- data_in_v2  in  DATA_WIDTH  v2 element.
- data_in_v2_full  out  1  v2 FIFO full.
- data_out_en  in  1  read strobe for the output FIFO.
- data_out  out  DATA_WIDTH  registered read data.
- data_out_empty  out  1  output FIFO empty (combinational from occupancy).
- vector_length  in  LENGTH_BITS  number of elements in the operation; sampled on start.
- start  in  1  begin an operation (honoured only in IDLE).
- done  out  1  high in DONE state.
- idle  out  1  high in IDLE state.
- ready  out  1  high in COMPUTE state; inputs are accepted.

## Operation
- FSM states: IDLE, COMPUTE, DONE. Reset state: IDLE.
- IDLE -> COMPUTE:
  - Transition when start=1.
  - Latch vector_length into len_reg and clear the element counter.
- COMPUTE:
  - When both input FIFOs are non-empty and the output FIFO is not full, pop v1 and v2 heads and push (v1+v2) mod 2^DATA_WIDTH into the output FIFO.
  - Carry is discarded. The element counter increments on each push.
- COMPUTE -> DONE: on the edge where the counter reaches len_reg, including the push of the last element. If len_reg=0, go to DONE on the first COMPUTE cycle.
- DONE -> IDLE: when the output FIFO is empty at a rising edge. DONE lasts at least one cycle.
- Input FIFO writes are accepted only in COMPUTE. A write is ignored when the FIFO is full or the state is not COMPUTE.
- The two input FIFOs are independent. Excess elements beyond len_reg remain queued for the next operation.
- Output FIFO reads are accepted in any state when `data_out_en`=1 and the FIFO is not empty. `data_out` loads the head entry; otherwise it holds its value.
- FIFO behaviour:
  - Input FIFOs are show-ahead: the head is combinationally visible to the adder.
  - Simultaneous read and write on a FIFO are both performed. Occupancy is unchanged, including when the FIFO is full.
  - Pointers wrap modulo the depth.
- start is ignored in COMPUTE and DONE.
- Reset at any time:
  - FSM returns to IDLE and all FIFOs are emptied.
  - data_out=0 and counter=0.

## Timing
- Reset values:
  - idle=1, ready=0, done=0.
  - data_out=0, data_out_empty=1.
  - data_in_v1_full=0, data_in_v2_full=0.
- start sampled at edge E: ready=1 and idle=0 from E.
- An operand pair written at edge N is summed and pushed at edge N+1, so data_out_empty=0 after N+1.
- A read strobe at edge N+2 presents the sum on data_out after N+2.
- Sustained throughput: one element per cycle when writes and reads run every cycle.
- done rises after the edge that pushes the last sum and falls after the edge at which the output FIFO is observed empty. idle rises at that same edge.

## Test plan
- Reset -> idle=1, ready=0, done=0, data_out_empty=1, both full flags 0.
- vector_length=8, pulse start:
  - Next cycle ready=1.
  - Write v1=1..8 and v2=9..16 one pair per cycle, reading whenever not empty.
  - Outputs in order: 0x000A, 0x000C, ..., 0x0018. done asserts, then idle=1 after drain.
- Same vectors with no reads until done:
  - Output FIFO holds 8 entries; compute stalls when the FIFO is full.
  - Draining yields all 8 sums in order, then idle.
- Overflow: v1=0xFFFF, v2=0x0002 -> sum 0x0001.
- vector_length=0 with start -> DONE for 1 cycle, then IDLE, no output.
- Assert rst mid-COMPUTE -> next cycle idle=1, data_out_empty=1, data_out=0; writes while IDLE are ignored.
